// File: rtl/smbm_cmd_issuer.sv
// smbm_cmd_issuer: buffers ADD/DELETE/READ commands in a small FIFO and issues them one at a
// time to smbm, holding arguments until done, tracking list occupancy and reporting completion.
module smbm_cmd_issuer #(
    parameter int BIT_VEC_SIZE       = 256,
    parameter int BIT_VEC_SIZE_LOG   = 8,
    parameter int NUM_OF_METRICS     = 4,
    parameter int NUM_OF_METRICS_LOG = 2,
    parameter int FIFO_DEPTH         = 4,
    parameter int TIMEOUT            = 15
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            cmd_valid_i,
    output logic                            cmd_ready_o,
    input  logic [2:0]                      cmd_op_i,
    input  logic [BIT_VEC_SIZE_LOG-1:0]     cmd_id_i,
    input  logic [8*NUM_OF_METRICS-1:0]     cmd_metric_val_i,
    input  logic [BIT_VEC_SIZE-1:0]         cmd_in_i,
    input  logic [NUM_OF_METRICS_LOG-1:0]   cmd_metricX_i,
    input  logic [2:0]                      cmd_opcode_in_i,
    output logic [2:0]                      opcode_o,
    output logic [BIT_VEC_SIZE_LOG-1:0]     id_o,
    output logic [8*NUM_OF_METRICS-1:0]     metric_val_o,
    output logic [BIT_VEC_SIZE-1:0]         in_o,
    output logic [NUM_OF_METRICS_LOG-1:0]   metricX_o,
    output logic [2:0]                      opcode_in_o,
    input  logic                            smbm_done_i,
    output logic                            rsp_valid_o,
    output logic [2:0]                      rsp_op_o,
    output logic                            rsp_err_o,
    output logic [BIT_VEC_SIZE_LOG:0]       occupancy_o
);

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_DELETE = 3'b001;
    localparam logic [2:0] OP_READ   = 3'b010;
    localparam logic [2:0] OP_IDLE   = 3'b111;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = BIT_VEC_SIZE_LOG + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [2:0]                    op;
        logic [BIT_VEC_SIZE_LOG-1:0]   id;
        logic [8*NUM_OF_METRICS-1:0]   metric_val;
        logic [BIT_VEC_SIZE-1:0]       vec;
        logic [NUM_OF_METRICS_LOG-1:0] metricX;
        logic [2:0]                    opcode_in;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t             state_q, state_d;
    cmd_t               fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    cmd_t               issued_q, issued_d;
    logic [2:0]         opcode_q, opcode_d;
    logic [TO_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [2:0]         rsp_op_q, rsp_op_d;
    logic               rsp_err_q, rsp_err_d;
    logic [OCC_W-1:0]   occupancy_q, occupancy_d;

    cmd_t               push_cmd;
    cmd_t               head;
    logic               push;
    logic               pop;
    logic               head_legal;

    assign push_cmd = '{op: cmd_op_i, id: cmd_id_i, metric_val: cmd_metric_val_i,
                        vec: cmd_in_i, metricX: cmd_metricX_i, opcode_in: cmd_opcode_in_i};

    assign cmd_ready_o = (count_q != CNT_W'(FIFO_DEPTH));
    assign push        = cmd_valid_i && cmd_ready_o;
    assign pop         = (state_q == ST_IDLE) && (count_q != '0);
    assign head        = fifo_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_cmd;
        end
    end

    always_comb begin
        head_legal = 1'b0;
        case (head.op)
            OP_ADD:    head_legal = (occupancy_q != OCC_W'(BIT_VEC_SIZE));
            OP_DELETE: head_legal = (occupancy_q != '0);
            OP_READ:   head_legal = 1'b1;
            default:   head_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        issued_d    = issued_q;
        opcode_d    = OP_IDLE;
        wait_cnt_d  = wait_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_op_d    = rsp_op_q;
        rsp_err_d   = rsp_err_q;
        occupancy_d = occupancy_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    if (head_legal) begin
                        issued_d = head;
                        opcode_d = head.op;
                        state_d  = ST_ISSUE;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_op_d    = head.op;
                    end
                end
            end
            ST_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // Occupancy only moves on a confirmed completion, never on a timeout.
                if (smbm_done_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_op_d    = issued_q.op;
                    if (issued_q.op == OP_ADD) begin
                        occupancy_d = occupancy_q + OCC_W'(1);
                    end else if (issued_q.op == OP_DELETE) begin
                        occupancy_d = occupancy_q - OCC_W'(1);
                    end
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_op_d    = issued_q.op;
                    state_d     = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            opcode_q    <= OP_IDLE;
            wait_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_op_q    <= '0;
            rsp_err_q   <= 1'b0;
            occupancy_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            issued_q    <= issued_d;
            opcode_q    <= opcode_d;
            wait_cnt_q  <= wait_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_op_q    <= rsp_op_d;
            rsp_err_q   <= rsp_err_d;
            occupancy_q <= occupancy_d;
        end
    end

    assign opcode_o     = opcode_q;
    assign id_o         = issued_q.id;
    assign metric_val_o = issued_q.metric_val;
    assign in_o         = issued_q.vec;
    assign metricX_o    = issued_q.metricX;
    assign opcode_in_o  = issued_q.opcode_in;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_op_o     = rsp_op_q;
    assign rsp_err_o    = rsp_err_q;
    assign occupancy_o  = occupancy_q;

endmodule
